uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between `clients` requesters at packet granularity, using round-robin priority.
- Each requester presents a byte stream and flags the final byte of each packet with a last bit.
- The arbiter issues bytes to uart_tx, gated by uart_tx clear-to-send, and acknowledges each accepted byte.
- A starvation watchdog revokes the grant from a client that stalls mid-packet.

---
 rtl/uart_tx_arbiter_if.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Client-side byte streams and the uart_tx hookup for uart_tx_arbiter.
// master is the arbiter side; slave is the clients plus uart_tx.
interface uart_tx_arbiter_if #(
  parameter int clients = 2
);
  logic [clients-1:0]   tick_req;
  logic [8*clients-1:0] tick_data;
  logic [clients-1:0]   tick_last;
  logic                 tick_clear_to_send;
  logic                 get_send_request;
  logic [7:0]           get_send_data;
  logic [clients-1:0]   get_grant;
  logic [clients-1:0]   get_ack;
  logic [clients-1:0]   get_abort;
  logic                 get_busy;

  modport master (
    input  tick_req,
    input  tick_data,
    input  tick_last,
    input  tick_clear_to_send,
    output get_send_request,
    output get_send_data,
    output get_grant,
    output get_ack,
    output get_abort,
    output get_busy
  );

  modport slave (
    output tick_req,
    output tick_data,
    output tick_last,
    output tick_clear_to_send,
    input  get_send_request,
    input  get_send_data,
    input  get_grant,
    input  get_ack,
    input  get_abort,
    input  get_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx serializer.
// A watchdog revokes the grant of an owner that stalls mid-packet.
module uart_tx_arbiter #(
  parameter int clients        = 2,
  parameter int timeout_cycles = 64
) (
  input logic               clock,
  input logic               tick_reset,
  uart_tx_arbiter_if.master bus
);

  localparam int PW = (clients > 1) ? $clog2(clients) : 1;
  localparam int WW = (timeout_cycles > 0) ?
                      $clog2(timeout_cycles + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ISSUE,
    SETTLE
  } state_e;

  state_e             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      own_q;
  logic [WW-1:0]      wdog_q;
  logic               last_q;
  logic               send_req_q;
  logic [7:0]         send_data_q;
  logic [clients-1:0] grant_q;
  logic [clients-1:0] ack_q;
  logic [clients-1:0] abort_q;
  logic               busy_q;

  logic               pick_vld_d;
  logic [PW-1:0]      pick_d;
  logic [PW-1:0]      ptr_nx_d;
  logic               own_req_d;
  logic               own_last_d;
  logic [7:0]         own_data_d;
  logic [WW-1:0]      wdog_inc_d;
  logic               wdog_hit_d;

  // Lowest offset from the pointer wins; request order is irrelevant.
  always_comb begin : pick
    int c;
    c          = 0;
    pick_vld_d = 1'b0;
    pick_d     = '0;
    for (int k = clients - 1; k >= 0; k--) begin
      c = (int'(ptr_q) + k) % clients;
      if (bus.tick_req[PW'(c)]) begin
        pick_vld_d = 1'b1;
        pick_d     = PW'(c);
      end
    end
  end

  assign own_req_d  = bus.tick_req[own_q];
  assign own_last_d = bus.tick_last[own_q];
  assign own_data_d = bus.tick_data[{own_q, 3'b000} +: 8];

  assign ptr_nx_d = (int'(own_q) >= clients - 1) ?
                    '0 : own_q + 1'b1;

  assign wdog_inc_d = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
  assign wdog_hit_d = (timeout_cycles != 0) &&
                      (int'(wdog_inc_d) >= timeout_cycles);

  always_ff @(posedge clock) begin
    if (tick_reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      wdog_q      <= '0;
      last_q      <= 1'b0;
      send_req_q  <= 1'b0;
      send_data_q <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      abort_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      send_req_q <= 1'b0;
      ack_q      <= '0;
      abort_q    <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            own_q   <= pick_d;
            grant_q <= clients'(1) << pick_d;
            wdog_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (own_req_d && bus.tick_clear_to_send) begin
            send_req_q  <= 1'b1;
            send_data_q <= own_data_d;
            ack_q       <= clients'(1) << own_q;
            last_q      <= own_last_d;
            wdog_q      <= '0;
            state_q     <= ISSUE;
          end else if (!own_req_d) begin
            wdog_q <= wdog_inc_d;
            if (wdog_hit_d) begin
              abort_q <= clients'(1) << own_q;
              grant_q <= '0;
              ptr_q   <= ptr_nx_d;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        ISSUE: begin
          state_q <= SETTLE;
        end
        SETTLE: begin
          if (last_q) begin
            grant_q <= '0;
            ptr_q   <= ptr_nx_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= GRANT;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.get_send_request = send_req_q;
  assign bus.get_send_data    = send_data_q;
  assign bus.get_grant        = grant_q;
  assign bus.get_ack          = ack_q;
  assign bus.get_abort        = abort_q;
  assign bus.get_busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two clients, timeout of 8,
// and a small uart_tx model holding clear_to_send low 40 cycles per byte.
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  logic tick_reset = 1'b1;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.clients(2)) bus();

  uart_tx_arbiter #(
    .clients(2),
    .timeout_cycles(8)
  ) dut (
    .clock(clock),
    .tick_reset(tick_reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic uart_en = 1'b1;
  logic force_cts = 1'b0;
  logic m_cts = 1'b1;
  int   m_cnt = 0;

  logic [1:0] en = 2'b00;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sent_d[$];
  int         gseq[$];
  int         acks0, acks1, n_abort, gap_bad;
  int         cyc, ack0_cyc, abort_cyc;
  logic [1:0] abort_v, abort_g, prev_g;

  assign bus.tick_clear_to_send = uart_en ? m_cts : force_cts;

  always @(posedge clock) begin
    if (tick_reset) begin
      m_cts <= 1'b1;
      m_cnt <= 0;
    end else if (bus.get_send_request) begin
      m_cts <= 1'b0;
      m_cnt <= 40;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_cts <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    bus.tick_req[0]    = en[0] && (q0.size() > 0);
    bus.tick_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.tick_last[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.tick_req[1]     = en[1] && (q1.size() > 0);
    bus.tick_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    bus.tick_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  task automatic sample();
    if (bus.get_send_request) sent_d.push_back(bus.get_send_data);
    if (bus.get_ack[0]) begin
      acks0++;
      ack0_cyc = cyc;
      if (q0.size() > 0) q0.delete(0);
    end
    if (bus.get_ack[1]) begin
      acks1++;
      if (q1.size() > 0) q1.delete(0);
    end
    if (bus.get_abort != 2'b00) begin
      n_abort++;
      abort_cyc = cyc;
      abort_v = bus.get_abort;
      abort_g = bus.get_grant;
    end
    if (bus.get_grant != 2'b00 && bus.get_grant != prev_g) begin
      if (prev_g != 2'b00) gap_bad++;
      gseq.push_back(bus.get_grant[1] ? 1 : 0);
    end
    prev_g = bus.get_grant;
    cyc++;
  endtask

  task automatic run(input int n);
    drive();
    repeat (n) begin
      step();
      sample();
      drive();
    end
  endtask

  task automatic clr();
    sent_d.delete();
    gseq.delete();
    q0.delete();
    q1.delete();
    acks0 = 0; acks1 = 0; n_abort = 0; gap_bad = 0;
    cyc = 0; ack0_cyc = -100; abort_cyc = -100;
    abort_v = 2'b00; abort_g = 2'b11; prev_g = 2'b00;
  endtask

  task automatic rst();
    clr();
    en = 2'b00;
    uart_en = 1'b1;
    force_cts = 1'b0;
    tick_reset = 1'b1;
    drive();
    step();
    tick_reset = 1'b0;
    prev_g = bus.get_grant;
  endtask

  function automatic logic [31:0] pk();
    logic [31:0] v;
    v = 32'h0;
    foreach (sent_d[i]) v = {v[23:0], sent_d[i]};
    return v;
  endfunction

  function automatic int gpk();
    int v;
    v = 0;
    foreach (gseq[i]) v = v * 10 + gseq[i] + 1;
    return v;
  endfunction

  function automatic logic [21:0] outs();
    return {bus.get_send_request, bus.get_send_data, bus.get_grant,
            bus.get_ack, bus.get_abort, bus.get_busy, 5'b0};
  endfunction

  task automatic test_reset();
    clr();
    q0.push_back(9'h1AA);
    en = 2'b01;
    tick_reset = 1'b1;
    drive();
    step();
    total++;
    if (outs() !== 22'h0) begin
      bad++;
      $display("FAIL reset_outs got %h want 0", outs());
    end
    step();
    total++;
    if (bus.get_busy !== 1'b0 || bus.get_grant !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold got busy=%b grant=%b want 0/00",
               bus.get_busy, bus.get_grant);
    end
    tick_reset = 1'b0;
  endtask

  task automatic test_single();
    rst();
    q0.push_back(9'h041);
    q0.push_back(9'h042);
    q0.push_back(9'h143);
    en = 2'b01;
    run(200);
    total++;
    if (sent_d.size() != 3 || pk() !== 32'h00414243) begin
      bad++;
      $display("FAIL t1_data got %h n=%0d want 00414243 n=3",
               pk(), sent_d.size());
    end
    total++;
    if (acks0 != 3) begin
      bad++;
      $display("FAIL t1_acks got %0d want 3", acks0);
    end
    total++;
    if (gpk() != 1) begin
      bad++;
      $display("FAIL t1_grants got %0d want 1", gpk());
    end
    total++;
    if (bus.get_busy !== 1'b0 || bus.get_grant !== 2'b00) begin
      bad++;
      $display("FAIL t1_idle got busy=%b grant=%b want 0/00",
               bus.get_busy, bus.get_grant);
    end
    total++;
    if (bus.get_send_request !== 1'b0 || bus.get_send_data !== 8'h43) begin
      bad++;
      $display("FAIL t1_hold got req=%b data=%h want 0/43",
               bus.get_send_request, bus.get_send_data);
    end
  endtask

  task automatic test_alternate();
    rst();
    q0.push_back(9'h1A0);
    q0.push_back(9'h1A0);
    q1.push_back(9'h1B1);
    q1.push_back(9'h1B1);
    en = 2'b11;
    run(300);
    total++;
    if (sent_d.size() != 4 || pk() !== 32'hA0B1A0B1) begin
      bad++;
      $display("FAIL t2_data got %h n=%0d want A0B1A0B1 n=4",
               pk(), sent_d.size());
    end
    total++;
    if (gpk() != 1212) begin
      bad++;
      $display("FAIL t2_order got %0d want 1212", gpk());
    end
    total++;
    if (gap_bad != 0) begin
      bad++;
      $display("FAIL t2_gap got %0d want 0", gap_bad);
    end
  endtask

  task automatic test_no_preempt();
    rst();
    q1.push_back(9'h011);
    q1.push_back(9'h012);
    q1.push_back(9'h113);
    q0.push_back(9'h105);
    en = 2'b10;
    run(20);
    total++;
    if (q1.size() != 2 || bus.get_grant !== 2'b10) begin
      bad++;
      $display("FAIL t3_open got left=%0d grant=%b want 2/10",
               q1.size(), bus.get_grant);
    end
    en = 2'b11;
    run(300);
    total++;
    if (sent_d.size() != 4 || pk() !== 32'h11121305) begin
      bad++;
      $display("FAIL t3_data got %h want 11121305", pk());
    end
    total++;
    if (gpk() != 21 || gap_bad != 0) begin
      bad++;
      $display("FAIL t3_order got %0d gap=%0d want 21 gap=0",
               gpk(), gap_bad);
    end
  endtask

  task automatic test_watchdog();
    rst();
    q0.push_back(9'h031);
    q1.push_back(9'h132);
    en = 2'b11;
    run(150);
    total++;
    if (n_abort != 1 || abort_v !== 2'b01) begin
      bad++;
      $display("FAIL t4_abort got n=%0d v=%b want 1/01", n_abort, abort_v);
    end
    total++;
    if (abort_cyc - ack0_cyc != 10) begin
      bad++;
      $display("FAIL t4_delay got %0d want 10", abort_cyc - ack0_cyc);
    end
    total++;
    if (abort_g !== 2'b00) begin
      bad++;
      $display("FAIL t4_gclr got %b want 00", abort_g);
    end
    total++;
    if (gpk() != 12 || pk() !== 32'h00003132 || acks1 != 1) begin
      bad++;
      $display("FAIL t4_next got g=%0d d=%h a1=%0d want 12/3132/1",
               gpk(), pk(), acks1);
    end
  endtask

  task automatic test_cts_hold();
    rst();
    uart_en = 1'b0;
    force_cts = 1'b0;
    q0.push_back(9'h155);
    en = 2'b01;
    run(40);
    total++;
    if (sent_d.size() != 0 || n_abort != 0) begin
      bad++;
      $display("FAIL t5_wait got sends=%0d aborts=%0d want 0/0",
               sent_d.size(), n_abort);
    end
    total++;
    if (bus.get_grant !== 2'b01 || bus.get_busy !== 1'b1) begin
      bad++;
      $display("FAIL t5_held got grant=%b busy=%b want 01/1",
               bus.get_grant, bus.get_busy);
    end
    force_cts = 1'b1;
    run(1);
    total++;
    if (bus.get_send_request !== 1'b1 || bus.get_send_data !== 8'h55 ||
        bus.get_ack !== 2'b01) begin
      bad++;
      $display("FAIL t5_issue got req=%b data=%h ack=%b want 1/55/01",
               bus.get_send_request, bus.get_send_data, bus.get_ack);
    end
    run(5);
    total++;
    if (bus.get_busy !== 1'b0 || sent_d.size() != 1) begin
      bad++;
      $display("FAIL t5_done got busy=%b sends=%0d want 0/1",
               bus.get_busy, sent_d.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    rst();
    q0.push_back(9'h166);
    en = 2'b01;
    run(60);
    q1.push_back(9'h077);
    q1.push_back(9'h178);
    en = 2'b10;
    drive();
    k = 0;
    while (k < 60 && bus.get_ack[1] !== 1'b1) begin
      step();
      sample();
      drive();
      k++;
    end
    total++;
    if (bus.get_ack[1] !== 1'b1 || bus.get_send_data !== 8'h77) begin
      bad++;
      $display("FAIL t6_issue got ack=%b data=%h want 1/77",
               bus.get_ack[1], bus.get_send_data);
    end
    tick_reset = 1'b1;
    step();
    total++;
    if (outs() !== 22'h0) begin
      bad++;
      $display("FAIL t6_reset got %h want 0", outs());
    end
    tick_reset = 1'b0;
    clr();
    q0.push_back(9'h101);
    q1.push_back(9'h102);
    en = 2'b11;
    drive();
    step();
    total++;
    if (bus.get_grant !== 2'b01 || bus.get_abort !== 2'b00) begin
      bad++;
      $display("FAIL t6_ptr got grant=%b abort=%b want 01/00",
               bus.get_grant, bus.get_abort);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_no_preempt();
    test_watchdog();
    test_cts_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
